// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch / next-PC controller:
// next-PC select encodings, opcode constants, FSM state encodings.
package inst_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        SEL_NEXT = 2'd0,
        SEL_REL  = 2'd1,
        SEL_ABS  = 2'd2,
        SEL_HALT = 2'd3
    } sel_t;

    localparam logic [5:0] OP_BEQ          = 6'b000100;
    localparam logic [5:0] OP_BNE          = 6'b000101;
    localparam logic [5:0] OP_J            = 6'b000010;
    localparam logic [5:0] OP_HALT_DEFAULT = 6'b111111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_WAIT   = 3'd1,
        S_EXEC   = 3'd2,
        S_UPDATE = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    // Instruction words are 4-byte aligned; any low address bit set is an error.
    function automatic logic pc_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_branch_resolve.sv
// Combinational control-flow resolution: opcode plus ALU zero flag -> next-PC select.
module inst_fetch_ctrl_branch_resolve
    import inst_fetch_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OP = OP_HALT_DEFAULT
) (
    input  logic [5:0] opcode,
    input  logic       zero,
    output sel_t       sel
);

    // Halt opcode is checked first so a parameterised HALT_OP can never alias a branch.
    always_comb begin
        sel = SEL_NEXT;
        if (opcode == HALT_OP) begin
            sel = SEL_HALT;
        end else begin
            case (opcode)
                OP_BEQ:  sel = zero ? SEL_REL : SEL_NEXT;
                OP_BNE:  sel = zero ? SEL_NEXT : SEL_REL;
                OP_J:    sel = SEL_ABS;
                default: sel = SEL_NEXT;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Multi-cycle fetch / next-PC controller: fetches the word at pc over a
// req/ack handshake, hands it to the datapath, waits for execute completion,
// then strobes the PC register with the resolved next-PC select.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int         TIMEOUT = 16,
    parameter logic [5:0] HALT_OP = OP_HALT_DEFAULT
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] pc,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        exec_done,
    input  logic        zero,
    output logic [1:0]  sel,
    output logic [15:0] immd16,
    output logic [25:0] immd26,
    output logic        pc_update,
    output logic        halted,
    output logic        fetch_err
);

    localparam int                  TIMER_W    = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    state_t             state;
    state_t             next_state;
    logic [TIMER_W-1:0] timer;
    logic [31:0]        addr_q;
    logic [31:0]        inst_q;
    logic               inst_valid_q;
    sel_t               sel_q;
    sel_t               resolved_sel;
    logic               halted_q;
    logic               fetch_err_q;

    logic               issue;
    logic               accept;
    logic               timeout;
    logic               misalign;
    logic               resolve;

    inst_fetch_ctrl_branch_resolve #(
        .HALT_OP (HALT_OP)
    ) u_branch_resolve (
        .opcode (inst_q[31:26]),
        .zero   (zero),
        .sel    (resolved_sel)
    );

    // State register; reset returns to fetch regardless of any transaction in flight.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus one-cycle event flags consumed by the datapath registers.
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        accept     = 1'b0;
        timeout    = 1'b0;
        misalign   = 1'b0;
        resolve    = 1'b0;
        case (state)
            S_FETCH: begin
                if (pc_misaligned(pc)) begin
                    misalign   = 1'b1;
                    next_state = S_HALT;
                end else begin
                    issue      = 1'b1;
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    accept     = 1'b1;
                    next_state = S_EXEC;
                end else if (timer == TIMER_LAST) begin
                    timeout    = 1'b1;
                    next_state = S_HALT;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    resolve    = 1'b1;
                    next_state = S_UPDATE;
                end
            end
            S_UPDATE: begin
                next_state = (sel_q == SEL_HALT) ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                next_state = S_HALT;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // Address, instruction, timer, select and sticky status registers.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            addr_q       <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            timer        <= '0;
            sel_q        <= SEL_NEXT;
            halted_q     <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            inst_valid_q <= accept;
            if (issue) begin
                addr_q <= pc;
                timer  <= '0;
            end else if (state == S_WAIT && !accept && !timeout) begin
                timer <= timer + TIMER_W'(1);
            end
            if (accept) begin
                inst_q <= imem_rdata;
            end
            if (resolve) begin
                sel_q <= resolved_sel;
            end
            if (misalign || timeout) begin
                fetch_err_q <= 1'b1;
                halted_q    <= 1'b1;
                sel_q       <= SEL_NEXT;
            end
            if (state == S_UPDATE && sel_q == SEL_HALT) begin
                halted_q <= 1'b1;
            end
        end
    end

    // Request and PC strobe are decoded from state so reset drops them without a clock.
    assign imem_req   = (state == S_WAIT);
    assign pc_update  = (state == S_UPDATE);
    assign imem_addr  = addr_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign sel        = sel_q;
    assign immd16     = inst_q[15:0];
    assign immd26     = inst_q[25:0];
    assign halted     = halted_q;
    assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed self-checking bench for inst_fetch_ctrl.
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        RST;
    logic [31:0] pc;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        exec_done;
    logic        zero;
    logic [1:0]  sel;
    logic [15:0] immd16;
    logic [25:0] immd26;
    logic        pc_update;
    logic        halted;
    logic        fetch_err;

    int vectors;
    int miscompares;
    longint t_update;
    longint t_first;

    inst_fetch_ctrl dut (
        .clk        (clk),
        .RST        (RST),
        .pc         (pc),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .exec_done  (exec_done),
        .zero       (zero),
        .sel        (sel),
        .immd16     (immd16),
        .immd26     (immd26),
        .pc_update  (pc_update),
        .halted     (halted),
        .fetch_err  (fetch_err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Hold reset for two clocks, checking the asynchronous clear, then release.
    task automatic do_reset(input string tag);
        RST = 1'b0;
        #1;
        check({tag, ".req"},      {31'd0, imem_req},   32'd0);
        check({tag, ".pc_upd"},   {31'd0, pc_update},  32'd0);
        tick();
        tick();
        check({tag, ".inst"},     inst,                32'd0);
        check({tag, ".sel"},      {30'd0, sel},        32'd0);
        check({tag, ".valid"},    {31'd0, inst_valid}, 32'd0);
        check({tag, ".halted"},   {31'd0, halted},     32'd0);
        check({tag, ".ferr"},     {31'd0, fetch_err},  32'd0);
        RST = 1'b1;
    endtask

    // One complete instruction: fetch with ack_delay idle wait cycles, execute
    // with exec_done on the cycle after inst_valid, then the PC update strobe.
    task automatic fetch_exec(input logic [31:0] addr, input logic [31:0] word, input logic z,
                              input int ack_delay, input logic [1:0] exp_sel, input string tag);
        logic [31:0] w;
        w  = word;
        pc = addr;
        tick();
        check({tag, ".req"},  {31'd0, imem_req}, 32'd1);
        check({tag, ".addr"}, imem_addr,         addr);
        repeat (ack_delay) tick();
        if (ack_delay > 0) begin
            check({tag, ".req_held"}, {31'd0, imem_req},  32'd1);
            check({tag, ".no_err"},   {31'd0, fetch_err}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = w;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check({tag, ".valid"},  {31'd0, inst_valid}, 32'd1);
        check({tag, ".inst"},   inst,                w);
        check({tag, ".req_lo"}, {31'd0, imem_req},   32'd0);
        check({tag, ".immd16"}, {16'd0, immd16},     {16'd0, w[15:0]});
        check({tag, ".immd26"}, {6'd0, immd26},      {6'd0, w[25:0]});
        tick();
        check({tag, ".valid_lo"}, {31'd0, inst_valid}, 32'd0);
        check({tag, ".upd_early"}, {31'd0, pc_update}, 32'd0);
        exec_done = 1'b1;
        zero      = z;
        tick();
        exec_done = 1'b0;
        zero      = 1'b0;
        check({tag, ".upd"}, {31'd0, pc_update}, 32'd1);
        check({tag, ".sel"}, {30'd0, sel},       {30'd0, exp_sel});
        t_update = $time;
        tick();
        check({tag, ".upd_lo"}, {31'd0, pc_update}, 32'd0);
        check({tag, ".halted"}, {31'd0, halted},    {31'd0, exp_sel == 2'd3});
    endtask

    initial begin
        int seen_req;
        vectors     = 0;
        miscompares = 0;
        RST         = 1'b0;
        pc          = 32'd0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        exec_done   = 1'b0;
        zero        = 1'b0;
        #2;

        do_reset("rst0");

        fetch_exec(32'h0000_0000, 32'h2001_0005, 1'b0, 0, 2'd0, "addi");
        fetch_exec(32'h0000_0004, 32'h1000_0003, 1'b1, 0, 2'd1, "beq_taken");
        t_first = t_update;
        fetch_exec(32'h0000_0008, 32'h1000_0003, 1'b0, 0, 2'd0, "beq_not");
        check("period", 32'(t_update - t_first), 32'd50);
        fetch_exec(32'h0000_000C, 32'h1400_0007, 1'b0, 0, 2'd1, "bne_taken");
        fetch_exec(32'h0000_0010, 32'h0800_0040, 1'b0, 0, 2'd2, "jump");
        check("jump.immd26", {6'd0, immd26}, 32'h0000_0040);
        fetch_exec(32'h0000_0014, 32'h2002_0001, 1'b0, 15, 2'd0, "ack_last");
        check("ack_last.ferr", {31'd0, fetch_err}, 32'd0);
        fetch_exec(32'h0000_0018, 32'hFC00_0000, 1'b0, 0, 2'd3, "halt");

        seen_req = 0;
        repeat (20) begin
            tick();
            if (imem_req || pc_update) seen_req = 1;
        end
        check("halt.quiet",  32'(seen_req),          32'd0);
        check("halt.sel",    {30'd0, sel},           32'd3);
        check("halt.ferr",   {31'd0, fetch_err},     32'd0);

        do_reset("rst1");
        pc = 32'h0000_0100;
        tick();
        check("tmo.req", {31'd0, imem_req}, 32'd1);
        repeat (15) tick();
        check("tmo.req_held", {31'd0, imem_req},  32'd1);
        check("tmo.no_err",   {31'd0, fetch_err}, 32'd0);
        tick();
        check("tmo.ferr",   {31'd0, fetch_err}, 32'd1);
        check("tmo.halted", {31'd0, halted},    32'd1);
        check("tmo.req_lo", {31'd0, imem_req},  32'd0);
        check("tmo.sel",    {30'd0, sel},       32'd0);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("tmo.late_ack", {31'd0, inst_valid}, 32'd0);

        do_reset("rst2");
        pc = 32'h0000_0002;
        tick();
        check("mis.ferr",   {31'd0, fetch_err}, 32'd1);
        check("mis.halted", {31'd0, halted},    32'd1);
        check("mis.req",    {31'd0, imem_req},  32'd0);

        do_reset("rst3");
        pc = 32'h0000_0020;
        tick();
        check("mid.req", {31'd0, imem_req}, 32'd1);
        RST = 1'b0;
        #1;
        check("mid.req_drop", {31'd0, imem_req}, 32'd0);
        tick();
        RST = 1'b1;
        fetch_exec(32'h0000_0020, 32'h0800_0123, 1'b0, 0, 2'd2, "refetch");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
